gray_decoder: RTL and testbench

GRAY_DECODER -- requirements
Module: gray_decoder

---
 rtl/gray_pkg.sv | 37 +++
 rtl/sync_2ff.sv | 38 +++
 rtl/gray_decoder.sv | 139 +++++++++++++
 tb/tb_gray_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the Gray-count decoder:
//   GRAY_WIDTH  - default width of the Gray / binary count
//   ERR_CNT_DEF - default width of the saturating error counter
//   state_t     - decoder FSM states
//   ACQ_LAST    - last value of the ACQUIRE flush counter before loading
//   gray2bin    - reference Gray-to-binary conversion for up to 32 bits
// -----------------------------------------------------------------------------
package gray_pkg;

  localparam int GRAY_WIDTH  = 4;
  localparam int ERR_CNT_DEF = 8;
  localparam int GRAY_MAX_W  = 32;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    LOCKED  = 2'd1,
    FAULT   = 2'd2
  } state_t;

  // Two cycles of synchronizer flush, the load happens while the counter
  // holds this value.
  localparam logic [1:0] ACQ_LAST = 2'd2;

  // Each binary bit is the XOR of all Gray bits at or above it. Narrower
  // counts can be zero-extended: leading zeros do not change the result.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a multi-bit Gray count. Because a Gray count
// changes only one bit per advance, bitwise synchronization is safe.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, clears both stages to 0
//   d    - asynchronous input vector
//   s1   - first stage (possibly metastable, not for use by logic)
//   s2   - second stage, safe to use in the clk domain
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] s1,
  output logic [WIDTH-1:0] s2
);

  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= d;
      s2_reg <= s1_reg;
    end
  end

  assign s1 = s1_reg;
  assign s2 = s2_reg;

endmodule

// File: rtl/gray_decoder.sv
// -----------------------------------------------------------------------------
// gray_decoder
// Synchronizes a Gray count from a free-running up-counter, decodes it to
// binary and tracks it with a small FSM that accepts only +1 advances.
// Ports:
//   clk      - clock, all state on rising edge
//   rst      - asynchronous active-high reset
//   gray_in  - Gray count, possibly from another clock domain
//   clr_err  - synchronous clear of err_cnt
//   bin_out  - binary value of the last accepted sample
//   step     - one-cycle pulse on an accepted +1 advance (incl. wrap)
//   err      - one-cycle pulse on an illegal transition
//   locked   - high while the FSM is in LOCKED
//   err_cnt  - saturating count of err pulses
// -----------------------------------------------------------------------------
module gray_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH     = GRAY_WIDTH,
  parameter int ERR_CNT_W = ERR_CNT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 step,
  output logic                 err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] bin_s2;
  logic [WIDTH-1:0] bin_inc;
  logic             err_detect;

  state_t                 state_reg;
  logic [1:0]             acq_cnt_reg;
  logic [WIDTH-1:0]       bin_out_reg;
  logic                   step_reg;
  logic                   err_reg;
  logic                   locked_reg;
  logic [ERR_CNT_W-1:0]   err_cnt_reg;

  sync_2ff #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gray_in),
    .s1  (s1),
    .s2  (s2)
  );

  // Gray to binary on the synchronized sample: bit i is the XOR of s2[WIDTH-1:i].
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bin
    assign bin_s2[gi] = ^s2[WIDTH-1:gi];
  end

  // Natural WIDTH-bit overflow gives the wrap from all-ones to zero.
  assign bin_inc = bin_out_reg + WIDTH'(1);

  // Anything other than "unchanged" or "+1" while locked is illegal.
  assign err_detect = (state_reg == LOCKED) &&
                      (bin_s2 != bin_out_reg) &&
                      (bin_s2 != bin_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ACQUIRE;
      acq_cnt_reg <= '0;
      bin_out_reg <= '0;
      step_reg    <= 1'b0;
      err_reg     <= 1'b0;
      locked_reg  <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      step_reg <= 1'b0;
      err_reg  <= 1'b0;

      case (state_reg)
        ACQUIRE: begin
          locked_reg <= 1'b0;
          if (acq_cnt_reg == ACQ_LAST) begin
            bin_out_reg <= bin_s2;
            acq_cnt_reg <= '0;
            state_reg   <= LOCKED;
            locked_reg  <= 1'b1;
          end else begin
            acq_cnt_reg <= acq_cnt_reg + 2'd1;
          end
        end

        LOCKED: begin
          if (err_detect) begin
            // bin_out keeps the last good value during the error cycle.
            err_reg    <= 1'b1;
            state_reg  <= FAULT;
            locked_reg <= 1'b0;
          end else if (bin_s2 == bin_inc) begin
            bin_out_reg <= bin_s2;
            step_reg    <= 1'b1;
          end
        end

        FAULT: begin
          // Resynchronize to whatever the counter shows now.
          bin_out_reg <= bin_s2;
          state_reg   <= LOCKED;
          locked_reg  <= 1'b1;
        end

        default: begin
          state_reg   <= ACQUIRE;
          acq_cnt_reg <= '0;
          locked_reg  <= 1'b0;
        end
      endcase

      // A clear that coincides with a new error keeps that error counted.
      if (clr_err) begin
        err_cnt_reg <= err_detect ? ERR_CNT_W'(1) : '0;
      end else if (err_detect && (err_cnt_reg != ERR_MAX)) begin
        err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
      end
    end
  end

  assign bin_out = bin_out_reg;
  assign step    = step_reg;
  assign err     = err_reg;
  assign locked  = locked_reg;
  assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_gray_decoder.sv
// -----------------------------------------------------------------------------
// tb_gray_decoder
// Directed bench for gray_decoder (WIDTH=4, ERR_CNT_W=8). Each table row is
// driven just after a falling edge and its expected outputs are compared at
// the next falling edge, so a gray_in change shows up two rows later.
// -----------------------------------------------------------------------------
module tb_gray_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] gray_in;
  logic       clr_err;
  logic [3:0] bin_out;
  logic       step;
  logic       err;
  logic       locked;
  logic [7:0] err_cnt;

  int checks   = 0;
  int failures = 0;
  int err_seen = 0;

  typedef struct {
    logic [3:0] gray;
    logic       clr;
    logic [3:0] bin;
    logic       stp;
    logic       er;
    logic       lck;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  gray_decoder #(
    .WIDTH     (4),
    .ERR_CNT_W (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .gray_in (gray_in),
    .clr_err (clr_err),
    .bin_out (bin_out),
    .step    (step),
    .err     (err),
    .locked  (locked),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gray encoding as produced by the upstream gray_counter.
  function automatic logic [3:0] g(input int v);
    logic [3:0] b;
    b = 4'(v);
    return b ^ (b >> 1);
  endfunction

  function automatic void add(input logic [3:0] gr, input logic cl,
                              input logic [3:0] bn, input logic st,
                              input logic er, input logic lk,
                              input logic [7:0] ec);
    vec_t v;
    v.gray = gr; v.clr = cl; v.bin = bn; v.stp = st;
    v.er = er; v.lck = lk; v.ecnt = ec;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] bn, input logic st,
                         input logic er, input logic lk, input logic [7:0] ec);
    chk({tag, ".bin_out"}, 32'(bin_out), 32'(bn));
    chk({tag, ".step"},    32'(step),    32'(st));
    chk({tag, ".err"},     32'(err),     32'(er));
    chk({tag, ".locked"},  32'(locked),  32'(lk));
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(ec));
  endtask

  task automatic drive_cycle(input logic [3:0] gr, input logic cl);
    gray_in = gr;
    clr_err = cl;
    @(negedge clk);
  endtask

  // step and err must be mutually exclusive; err pulses are tallied.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (step && err) begin
        failures++;
        $display("FAIL step_err_overlap actual=1 required=0 at %0t", $time);
      end
      if (err) err_seen++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    gray_in = 4'b0000;
    clr_err = 1'b0;

    // ---------------- table ----------------
    // Acquire: two flush cycles, lock on the third edge.
    add(4'b0000, 0, 4'd0, 0, 0, 0, 8'd0);
    add(4'b0000, 0, 4'd0, 0, 0, 0, 8'd0);
    add(4'b0000, 0, 4'd0, 0, 0, 1, 8'd0);
    // Count 1..15 one value per cycle.
    add(g(1), 0, 4'd0, 0, 0, 1, 8'd0);
    add(g(2), 0, 4'd0, 0, 0, 1, 8'd0);
    for (int v = 3; v <= 15; v++) add(g(v), 0, 4'(v - 2), 1, 0, 1, 8'd0);
    add(g(15), 0, 4'd14, 1, 0, 1, 8'd0);
    add(g(15), 0, 4'd15, 1, 0, 1, 8'd0);
    add(g(15), 0, 4'd15, 0, 0, 1, 8'd0);
    // Wrap 15 (1000) -> 0 (0000).
    add(4'b0000, 0, 4'd15, 0, 0, 1, 8'd0);
    add(4'b0000, 0, 4'd15, 0, 0, 1, 8'd0);
    add(4'b0000, 0, 4'd0,  1, 0, 1, 8'd0);
    add(4'b0000, 0, 4'd0,  0, 0, 1, 8'd0);
    // Climb to 3 (0010), then jump to 0111 (bin 5).
    add(4'b0001, 0, 4'd0, 0, 0, 1, 8'd0);
    add(4'b0011, 0, 4'd0, 0, 0, 1, 8'd0);
    add(4'b0010, 0, 4'd1, 1, 0, 1, 8'd0);
    add(4'b0010, 0, 4'd2, 1, 0, 1, 8'd0);
    add(4'b0010, 0, 4'd3, 1, 0, 1, 8'd0);
    add(4'b0010, 0, 4'd3, 0, 0, 1, 8'd0);
    add(4'b0111, 0, 4'd3, 0, 0, 1, 8'd0);
    add(4'b0111, 0, 4'd3, 0, 0, 1, 8'd0);
    add(4'b0111, 0, 4'd3, 0, 1, 0, 8'd1);
    add(4'b0111, 0, 4'd5, 0, 0, 1, 8'd1);
    add(4'b0111, 0, 4'd5, 0, 0, 1, 8'd1);
    // Up to 6 (0101), then backward to 5 (0111).
    add(4'b0101, 0, 4'd5, 0, 0, 1, 8'd1);
    add(4'b0101, 0, 4'd5, 0, 0, 1, 8'd1);
    add(4'b0101, 0, 4'd6, 1, 0, 1, 8'd1);
    add(4'b0101, 0, 4'd6, 0, 0, 1, 8'd1);
    add(4'b0111, 0, 4'd6, 0, 0, 1, 8'd1);
    add(4'b0111, 0, 4'd6, 0, 0, 1, 8'd1);
    add(4'b0111, 0, 4'd6, 0, 1, 0, 8'd2);
    add(4'b0111, 0, 4'd5, 0, 0, 1, 8'd2);
    add(4'b0111, 0, 4'd5, 0, 0, 1, 8'd2);
    // Plain clear.
    add(4'b0111, 1, 4'd5, 0, 0, 1, 8'd0);
    add(4'b0111, 0, 4'd5, 0, 0, 1, 8'd0);

    // Reset state, sampled mid-reset.
    #1;
    chk_all("reset", 4'd0, 0, 0, 0, 8'd0);
    #11;
    rst = 1'b0;

    foreach (vecs[i]) begin
      gray_in = vecs[i].gray;
      clr_err = vecs[i].clr;
      @(negedge clk);
      chk_all($sformatf("row%0d", i), vecs[i].bin, vecs[i].stp, vecs[i].er,
              vecs[i].lck, vecs[i].ecnt);
    end

    // ---------------- saturation: 300 errors ----------------
    err_seen = 0;
    for (int k = 0; k < 150; k++) begin
      repeat (3) drive_cycle(4'b0000, 1'b0);
      repeat (3) drive_cycle(4'b0111, 1'b0);
    end
    repeat (2) drive_cycle(4'b0111, 1'b0);
    chk("sat.err_pulses", 32'(err_seen), 32'd300);
    chk_all("sat", 4'd5, 0, 0, 1, 8'd255);

    // ---------------- clear coincident with an error ----------------
    drive_cycle(4'b0000, 1'b0);
    drive_cycle(4'b0000, 1'b0);
    chk("clr_err.pre", 32'(err_cnt), 32'd255);
    drive_cycle(4'b0000, 1'b1);
    chk_all("clr_err.hit", 4'd5, 0, 1, 0, 8'd1);
    drive_cycle(4'b0000, 1'b0);
    chk_all("clr_err.post", 4'd0, 0, 0, 1, 8'd1);

    // ---------------- async reset while at 9 ----------------
    for (int v = 1; v <= 9; v++) drive_cycle(g(v), 1'b0);
    repeat (3) drive_cycle(g(9), 1'b0);
    chk_all("pre_rst", 4'd9, 0, 0, 1, 8'd1);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    gray_in = g(12);
    #1;
    chk_all("async_rst", 4'd0, 0, 0, 0, 8'd0);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk_all("reacq0", 4'd0, 0, 0, 0, 8'd0);
    @(negedge clk);
    chk_all("reacq1", 4'd0, 0, 0, 0, 8'd0);
    @(negedge clk);
    chk_all("reacq2", 4'd0, 0, 0, 0, 8'd0);
    @(negedge clk);
    chk_all("reacq3", 4'd12, 0, 0, 1, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
